// File: rtl/qspi_psram_pkg.sv
// Shared opcodes, FSM states and frame constants for the QSPI PSRAM responder and its controller.
package qspi_psram_pkg;

    localparam logic [7:0] CMD_RSTEN    = 8'h66;
    localparam logic [7:0] CMD_RST      = 8'h99;
    localparam logic [7:0] CMD_QPI      = 8'h35;
    localparam logic [7:0] CMD_QPI_EXIT = 8'hF5;
    localparam logic [7:0] CMD_READ     = 8'hEB;
    localparam logic [7:0] CMD_WRITE    = 8'h38;

    localparam int unsigned ADDR_NIBBLES = 6;

    typedef enum logic [2:0] {
        IDLE,
        SPI_CMD,
        QPI_CMD,
        ADDR,
        WAIT,
        RD_DATA,
        WR_DATA,
        IGNORE
    } state_t;

endpackage

// File: rtl/qspi_resp_mem.sv
// Single-port byte RAM with synchronous read and write enable; contents survive reset.
module qspi_resp_mem #(
    parameter int unsigned ADDR_W = 10
) (
    input  logic              clk,
    input  logic              we,
    input  logic [ADDR_W-1:0] addr,
    input  logic [7:0]        wdata,
    output logic [7:0]        rdata
);

    logic [7:0] mem [0:(1 << ADDR_W) - 1];

    always_ff @(posedge clk) begin
        if (we) begin
            mem[addr] <= wdata;
        end
        rdata <= mem[addr];
    end

endmodule

// File: rtl/qspi_psram_responder.sv
// Target-side QSPI PSRAM model: SPI/QPI command decode, QPI burst read/write into a byte RAM.
// Optional build macro QSPI_RESP_PAGE_WRAP_EN confines burst increments to a 2^PAGE_LOG2 page.
module qspi_psram_responder
    import qspi_psram_pkg::*;
#(
    parameter int unsigned DEPTH_LOG2  = 10,
    parameter int unsigned WAIT_CYCLES = 6,
    parameter int unsigned PAGE_LOG2   = 10
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       ce_n,
    input  logic [3:0] sio_in,
    output logic [3:0] sio_out,
    output logic       sio_oe,
    output logic       qpi_mode,
    output logic       busy,
    output logic       cmd_error
);

    localparam int unsigned AW = DEPTH_LOG2;

    if (PAGE_LOG2 > DEPTH_LOG2 || WAIT_CYCLES < 2) begin : g_param_check
        $error("qspi_psram_responder: need PAGE_LOG2 <= DEPTH_LOG2 and WAIT_CYCLES >= 2");
    end

    state_t        state;
    logic [6:0]    shift;
    logic [7:0]    cnt;
    logic [AW-1:0] addr;
    logic [3:0]    hold;
    logic          phase;
    logic          is_read;
    logic          rst_armed;
    logic          need_idle;
    logic [7:0]    rdata;
    logic          mem_we;
    logic [7:0]    spi_op;
    logic [7:0]    qpi_op;

    assign spi_op = {shift, sio_in[0]};
    assign qpi_op = {shift[3:0], sio_in};
    // Write strobe is blocked by rst and by ce_n rising on the 2nd nibble
    assign mem_we = !rst && !ce_n && (state == WR_DATA) && phase;

`ifdef QSPI_RESP_PAGE_WRAP_EN
    localparam logic [AW-1:0] PAGE_MASK = AW'((64'd1 << PAGE_LOG2) - 64'd1);

    function automatic logic [AW-1:0] next_addr(input logic [AW-1:0] a);
        next_addr = (a & ~PAGE_MASK) | ((a + AW'(1)) & PAGE_MASK);
    endfunction
`else
    function automatic logic [AW-1:0] next_addr(input logic [AW-1:0] a);
        next_addr = a + AW'(1);
    endfunction
`endif

    qspi_resp_mem #(
        .ADDR_W (AW)
    ) u_mem (
        .clk   (clk),
        .we    (mem_we),
        .addr  (addr),
        .wdata ({hold, sio_in}),
        .rdata (rdata)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            sio_out   <= 4'h0;
            sio_oe    <= 1'b0;
            qpi_mode  <= 1'b0;
            busy      <= 1'b0;
            cmd_error <= 1'b0;
            rst_armed <= 1'b0;
            need_idle <= 1'b1;
            shift     <= 7'h0;
            cnt       <= 8'h0;
            addr      <= '0;
            hold      <= 4'h0;
            phase     <= 1'b0;
            is_read   <= 1'b0;
        end else begin
            busy      <= ~ce_n;
            cmd_error <= 1'b0;
            if (ce_n) begin
                state     <= IDLE;
                sio_oe    <= 1'b0;
                need_idle <= 1'b0;
            end else begin
                case (state)
                    IDLE: begin
                        // A frame cut by rst is not picked up again until ce_n has been high
                        if (!need_idle) begin
                            cnt <= 8'd1;
                            if (qpi_mode) begin
                                shift <= 7'(sio_in);
                                state <= QPI_CMD;
                            end else begin
                                shift <= 7'(sio_in[0]);
                                state <= SPI_CMD;
                            end
                        end
                    end
                    SPI_CMD: begin
                        shift <= spi_op[6:0];
                        cnt   <= cnt + 8'd1;
                        if (cnt == 8'd7) begin
                            state     <= IGNORE;
                            rst_armed <= (spi_op == CMD_RSTEN);
                            case (spi_op)
                                CMD_RSTEN: ;
                                CMD_RST:   if (rst_armed) qpi_mode <= 1'b0;
                                CMD_QPI:   qpi_mode <= 1'b1;
                                default:   cmd_error <= 1'b1;
                            endcase
                        end
                    end
                    QPI_CMD: begin
                        cnt       <= 8'd0;
                        state     <= IGNORE;
                        rst_armed <= (qpi_op == CMD_RSTEN);
                        case (qpi_op)
                            CMD_RSTEN:    ;
                            CMD_RST:      if (rst_armed) qpi_mode <= 1'b0;
                            CMD_QPI_EXIT: qpi_mode <= 1'b0;
                            CMD_READ: begin
                                is_read <= 1'b1;
                                state   <= ADDR;
                            end
                            CMD_WRITE: begin
                                is_read <= 1'b0;
                                state   <= ADDR;
                            end
                            default:      cmd_error <= 1'b1;
                        endcase
                    end
                    ADDR: begin
                        // Only the low AW address bits are kept; upper bits alias
                        addr <= AW'({addr, sio_in});
                        cnt  <= cnt + 8'd1;
                        if (cnt == 8'(ADDR_NIBBLES - 1)) begin
                            cnt   <= 8'd0;
                            phase <= 1'b0;
                            state <= is_read ? WAIT : WR_DATA;
                        end
                    end
                    WAIT: begin
                        cnt <= cnt + 8'd1;
                        if (cnt == 8'(WAIT_CYCLES - 1)) begin
                            state <= RD_DATA;
                        end
                    end
                    RD_DATA: begin
                        // RAM output for addr+1 settles during the low-nibble cycle
                        sio_oe <= 1'b1;
                        phase  <= ~phase;
                        if (!phase) begin
                            sio_out <= rdata[7:4];
                            hold    <= rdata[3:0];
                            addr    <= next_addr(addr);
                        end else begin
                            sio_out <= hold;
                        end
                    end
                    WR_DATA: begin
                        phase <= ~phase;
                        if (!phase) begin
                            hold <= sio_in;
                        end else begin
                            addr <= next_addr(addr);
                        end
                    end
                    IGNORE: ;
                    default: state <= IGNORE;
                endcase
            end
        end
    end

endmodule
